alu_executor: RTL and testbench
===============================

ALU_EXECUTOR -- requirements
Module: alu_executor

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; SHALL be a multiple of DIGIT.
REQ-002 Parameter DIGIT, default 4: bits processed per EXEC cycle; WIDTH/DIGIT is the execution length N (8 at defaults).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  request valid; alu_ctrl, src_a and src_b are meaningful while high.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 alu_ctrl  input  3  operation code: 010 add, 110 sub, 000 and, 001 or, 111 slt; 011, 100 and 101 are illegal.
REQ-008 src_a  input  WIDTH  first operand.
REQ-009 src_b  input  WIDTH  second operand.
REQ-010 out_valid  output  1  result, zero and illegal are valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  result equals 0.
REQ-014 illegal  output  1  the completed request carried an illegal alu_ctrl code.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EXEC and DONE.
REQ-016 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only; at most one request SHALL be in flight.
REQ-017 Accept: in IDLE with in_valid=1, the block SHALL capture alu_ctrl, src_a and src_b, clear the digit counter, and move to EXEC for legal codes or to DONE for illegal codes.
REQ-018 On capture the block SHALL set the carry to 1 and store ~src_b for sub and slt, and SHALL set the carry to 0 and store src_b for all other codes.
REQ-019 EXEC, each cycle: the block SHALL process one DIGIT-bit slice, LSB slice first, write it into the result register and propagate the carry into the next slice; the counter SHALL increment by 1.
REQ-020 EXEC SHALL last exactly N cycles; on the cycle the counter reaches N-1, the next state SHALL be DONE.
REQ-021 out_valid SHALL rise exactly N+1 rising edges after the accepting edge for legal codes, and exactly 1 edge after it for illegal codes.
REQ-022 add and sub results SHALL be modulo 2^WIDTH; the carry-out and overflow SHALL be discarded.
REQ-023 and and or SHALL be bitwise; the carry SHALL be ignored.
REQ-024 slt SHALL be a signed compare: result = 1 when src_a < src_b, else 0, zero-extended to WIDTH; when the signs differ the outcome SHALL be src_a's sign bit, otherwise the sign bit of src_a-src_b.
REQ-025 For an illegal code: result=0, zero=1, illegal=1.
REQ-026 For a legal code: illegal=0, and zero=(result==0) at DONE.
REQ-027 In DONE, result, zero and illegal SHALL hold stable until out_ready=1; on that cycle the block SHALL return to IDLE.
REQ-028 A new request SHALL NOT be accepted in the same cycle that DONE is left; the earliest accept is the following IDLE cycle.
REQ-029 Captured operands SHALL NOT be affected by changes on src_a, src_b or alu_ctrl after the accepting edge.
REQ-030 in_valid in EXEC or DONE SHALL be ignored; the requester holds it.

Reset
REQ-031 When rst_n=0 at a rising edge, the block SHALL go to IDLE and clear the counter, carry, captured operands and result.
REQ-032 Reset values: in_ready=1, out_valid=0, result=0, zero=0, illegal=0.
REQ-033 Reset in EXEC or DONE SHALL abort the operation; the pending result SHALL never be presented.
REQ-034 In the first cycle with rst_n=1 the block SHALL be in IDLE and able to accept a request.

Verification
REQ-035 add, 5 + 7 -> after 9 edges: out_valid=1, result=0x0000000C, zero=0, illegal=0; 0xFFFFFFFF + 1 -> result=0, zero=1.
REQ-036 sub, 3 - 5 -> result=0xFFFFFFFE; and, 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000; or, same operands -> 0xFFF0FFF0.
REQ-037 slt, 0xFFFFFFFF vs 1 -> result=1; 0x7FFFFFFF vs 0x80000000 -> result=0; 5 vs 5 -> result=0, zero=1.
REQ-038 alu_ctrl=011 -> out_valid 1 edge after accept, result=0, zero=1, illegal=1; a following add SHALL report illegal=0.
REQ-039 Back-pressure, out_ready=0 for 5 cycles in DONE -> out_valid and result held stable and in_ready=0; src_a toggled during EXEC leaves the result unchanged.
REQ-040 Reset mid-operation, rst_n=0 for one edge at EXEC counter=3 -> next cycle IDLE, in_ready=1, out_valid=0, result=0; a new request then completes correctly.

Source files
------------

// File: rtl/alu_executor.sv
// Digit-serial ALU: add/sub/and/or/slt over WIDTH bits, DIGIT bits per cycle.
// One request in flight; IDLE -> EXEC (N cycles) -> DONE, held until out_ready.
module alu_executor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_reg, b_reg, res;
  logic             zero_r, ill_r;

  logic [DIGIT-1:0] a_sl, b_sl, slice;
  logic [DIGIT:0]   sum;
  logic             lt, last, in_legal, in_inv;
  logic [WIDTH-1:0] nres, fin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res;
  assign zero      = zero_r;
  assign illegal   = ill_r;

  assign in_legal = (alu_ctrl == OP_AND) || (alu_ctrl == OP_OR) || (alu_ctrl == OP_ADD) ||
                    (alu_ctrl == OP_SUB) || (alu_ctrl == OP_SLT);
  assign in_inv   = (alu_ctrl == OP_SUB) || (alu_ctrl == OP_SLT);
  assign last     = (cnt == CW'(N - 1));

  // Operands shift right each cycle, so the active slice is always the low digit;
  // result slices enter from the top and reach their final place after N cycles.
  always_comb begin
    a_sl  = a_reg[DIGIT-1:0];
    b_sl  = b_reg[DIGIT-1:0];
    sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry};
    slice = sum[DIGIT-1:0];
    case (op)
      OP_AND:  slice = a_sl & b_sl;
      OP_OR:   slice = a_sl | b_sl;
      default: slice = sum[DIGIT-1:0];
    endcase
    nres = (res >> DIGIT) | ({{(WIDTH-DIGIT){1'b0}}, slice} << (WIDTH - DIGIT));
    // b_reg holds ~src_b: equal stored sign bits mean the original signs differ.
    lt   = (a_sl[DIGIT-1] == b_sl[DIGIT-1]) ? a_sl[DIGIT-1] : sum[DIGIT-1];
    fin  = (op == OP_SLT) ? {{(WIDTH-1){1'b0}}, lt} : nres;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      op     <= 3'b000;
      a_reg  <= '0;
      b_reg  <= '0;
      res    <= '0;
      zero_r <= 1'b0;
      ill_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op    <= alu_ctrl;
          a_reg <= src_a;
          b_reg <= in_inv ? ~src_b : src_b;
          carry <= in_inv;
          cnt   <= '0;
          res   <= '0;
          ill_r <= ~in_legal;
          zero_r <= ~in_legal;
          state <= in_legal ? EXEC : DONE;
        end
        EXEC: begin
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          carry <= sum[DIGIT];
          cnt   <= cnt + CW'(1);
          if (last) begin
            res    <= fin;
            zero_r <= (fin == '0);
            state  <= DONE;
          end else begin
            res <= nres;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_executor.sv
// Scoreboarded random + directed bench for alu_executor at default parameters.
module tb_alu_executor;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [2:0]  alu_ctrl;
  logic [31:0] src_a, src_b, result;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0, n_bad = 0, cyc = 0, bp = 0;

  alu_executor #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.ill = 1'b0;
    e.res = 32'd0;
    case (c)
      3'b010:  e.res = a + b;
      3'b110:  e.res = a - b;
      3'b000:  e.res = a & b;
      3'b001:  e.res = a | b;
      3'b111:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.ill = 1'b1;
    endcase
    e.z   = e.ill ? 1'b1 : (e.res == 32'd0);
    e.lat = e.ill ? 1 : 9;
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   w;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = c; src_a = a; src_b = b;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
      in_valid = 1'b0;
      return;
    end
    e = model(c, a, b);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    // Inputs change right after capture; the in-flight result must not notice.
    in_valid = 1'b0; src_a = ~a; src_b = $urandom; alu_ctrl = 3'($urandom);
  endtask

  task automatic drain();
    int w = 0;
    @(negedge clk);
    while (!(in_ready && q.size() == 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", q.size());
    end
  endtask

  // Monitor: compares each presented result once, then checks it stays stable while held.
  initial begin
    exp_t        e;
    logic        seen = 1'b0;
    logic [31:0] held = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
        if (!seen) begin
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL spurious_out: out_valid=1, expected no pending result");
          end else begin
            e = q.pop_front();
            chk("result",  result, e.res);
            chk("zero",    {31'd0, zero}, {31'd0, e.z});
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          end
          held = result;
          seen = 1'b1;
        end else begin
          chk("held_result", result, held);
        end
        if (bp > 0) begin
          out_ready = 1'b0;
          bp--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (out_ready) seen = 1'b0;
      end else begin
        seen = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_ctrl = 3'b000; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_zero",      {31'd0, zero},      32'd0);
    chk("rst_illegal",   {31'd0, illegal},   32'd0);
    rst_n = 1'b1;

    send(3'b010, 32'd5, 32'd7);
    send(3'b010, 32'hFFFF_FFFF, 32'd1);
    send(3'b110, 32'd3, 32'd5);
    send(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    send(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    send(3'b111, 32'hFFFF_FFFF, 32'd1);
    send(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
    send(3'b111, 32'd5, 32'd5);
    send(3'b011, 32'd9, 32'd9);
    send(3'b010, 32'd1, 32'd2);
    send(3'b100, 32'd1, 32'd1);
    send(3'b101, 32'd1, 32'd1);
    drain();

    bp = 5;
    send(3'b110, 32'h1234_5678, 32'h0000_0FFF);
    drain();

    // Abort at counter 3 of EXEC: nothing may be presented for this request.
    send(3'b010, 32'hAAAA_0000, 32'h0000_5555);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if (q.size() > 0) void'(q.pop_back());
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result",    result,             32'd0);
    send(3'b010, 32'd100, 32'd23);
    drain();

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) bp = $urandom_range(1, 6);
      send(3'($urandom), pick(), pick());
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
